// File: rtl/ts_out_stub_window_match.sv
// Multi-lane outer-stub z window match for tracklet seeding.
// A window is latched from an inner stub. Outer stubs then stream through, N_LANES per beat,
// and each beat yields a per-lane match mask two cycles later. At the end of the list a
// saturating match count and an any-match flag are presented with a one-cycle done pulse.
module ts_out_stub_window_match #(
  parameter int unsigned Z_BITS    = 12,
  parameter int unsigned N_LANES   = 4,
  parameter int unsigned CNT_BITS  = 6,
  parameter bit          INCL_HIGH = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        win_load,
  input  logic [Z_BITS-1:0]           z_lim_low,
  input  logic [Z_BITS-1:0]           z_lim_high,
  output logic                        win_ready,
  input  logic                        stub_valid,
  input  logic                        stub_last,
  input  logic [N_LANES-1:0]          stub_lane_en,
  input  logic [N_LANES*Z_BITS-1:0]   stub_dat,
  output logic                        stub_drop,
  output logic                        match_valid,
  output logic [N_LANES-1:0]          match_mask,
  output logic                        done,
  output logic [CNT_BITS-1:0]         match_count,
  output logic                        any_match,
  output logic                        win_err
);

  localparam int unsigned PopW = $clog2(N_LANES + 1);
  localparam int unsigned SumW = CNT_BITS + PopW;
  localparam logic [CNT_BITS-1:0] CntMax = {CNT_BITS{1'b1}};

  typedef enum logic [2:0] {StIdle, StArmed, StScan, StFlush, StDone} state_e;

  state_e state_q, state_d;
  logic   flush_q, flush_d;

  logic                      accept;
  logic                      load_ok;
  logic signed [Z_BITS-1:0]  low_q, high_q;
  logic                      err_q;
  logic signed [Z_BITS-1:0]  lane_z;
  logic [N_LANES-1:0]        cmp_mask;
  logic                      s1_valid_q;
  logic [N_LANES-1:0]        s1_mask_q;
  logic                      s2_valid_q;
  logic [N_LANES-1:0]        s2_mask_q;
  logic [PopW-1:0]           pop;
  logic [SumW-1:0]           sum;
  logic [CNT_BITS-1:0]       count_q, count_d;
  logic                      drop_q;

  // A beat wins over a simultaneous load in ARMED, so the load is only taken without a beat.
  assign accept  = stub_valid & ((state_q == StArmed) | (state_q == StScan));
  assign load_ok = win_load & ((state_q == StIdle) | (state_q == StDone) |
                               ((state_q == StArmed) & ~stub_valid));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // FSM next state; FLUSH lasts two cycles so the count has absorbed the last mask
  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_ok) state_d = StArmed;
      end
      StArmed: begin
        if (stub_valid) state_d = stub_last ? StFlush : StScan;
      end
      StScan: begin
        if (stub_valid && stub_last) state_d = StFlush;
      end
      StFlush: begin
        flush_d = ~flush_q;
        if (flush_q) state_d = StDone;
      end
      StDone: begin
        state_d = load_ok ? StArmed : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM-derived outputs
  always_comb begin
    win_ready = (state_q == StIdle) | (state_q == StArmed) | (state_q == StDone);
    done      = (state_q == StDone);
    any_match = |count_q;
  end

  // Window bounds and inverted-window flag, captured on an accepted load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_q  <= '0;
      high_q <= '0;
      err_q  <= 1'b0;
    end else if (load_ok) begin
      low_q  <= $signed(z_lim_low);
      high_q <= $signed(z_lim_high);
      err_q  <= $signed(z_lim_low) > $signed(z_lim_high);
    end
  end

  // Per-lane signed compare against the held window
  always_comb begin
    cmp_mask = '0;
    lane_z   = '0;
    for (int k = 0; k < N_LANES; k++) begin
      lane_z = $signed(stub_dat[k*Z_BITS +: Z_BITS]);
      cmp_mask[k] = stub_lane_en[k] & ~err_q & (lane_z >= low_q) &
                    (INCL_HIGH ? (lane_z <= high_q) : (lane_z < high_q));
    end
  end

  // Two-stage match pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mask_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_mask_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_mask_q  <= accept ? cmp_mask : '0;
      s2_valid_q <= s1_valid_q;
      s2_mask_q  <= s1_mask_q;
    end
  end

  assign match_valid = s2_valid_q;
  assign match_mask  = s2_mask_q;

  // Saturating count of matched lanes; a load clears it
  always_comb begin
    pop = '0;
    for (int k = 0; k < N_LANES; k++) begin
      pop = pop + PopW'(s2_mask_q[k]);
    end
    sum     = SumW'(count_q) + SumW'(pop);
    count_d = count_q;
    if (load_ok) begin
      count_d = '0;
    end else if (s2_valid_q) begin
      count_d = (sum > SumW'(CntMax)) ? CntMax : sum[CNT_BITS-1:0];
    end
  end

  // Count register and drop pulse for beats arriving outside ARMED/SCAN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      drop_q  <= stub_valid & ~accept;
    end
  end

  assign match_count = count_q;
  assign stub_drop   = drop_q;
  assign win_err     = err_q;

endmodule
